// File: rtl/clk_div_checker.sv
// clk_div_checker
//   Measures the period of a divided clock (sampled as data in the clk
//   domain) between rising edges, compares it against EXP_PERIOD +/- TOL,
//   reports lock after LOCK_CNT consecutive good periods, and keeps a sticky
//   error flag plus a saturating error counter.
//
// Ports:
//   clk           system clock (same clock driving the divider)
//   reset         asynchronous, active-high reset
//   div_in        divided clock, synchronous to clk
//   enable        1 = checking active, 0 = idle
//   clear_err     single-cycle pulse clearing err / err_count
//   period        last measured period in clk cycles
//   period_valid  one-cycle pulse when period updates
//   locked        divider judged stable
//   err           sticky error flag
//   err_count     saturating count of error events
module clk_div_checker #(
  parameter int unsigned EXP_PERIOD = 4,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic             enable,
  input  logic             clear_err,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned GR_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic [ERR_W-1:0]        ERR_MAX = '1;
  localparam logic [GR_W-1:0]         GR_MAX  = GR_W'(LOCK_CNT);
  localparam logic signed [CNT_W:0]   EXP_S   = (CNT_W+1)'(EXP_PERIOD);
  localparam logic signed [CNT_W:0]   TOL_S   = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t           state, state_n;
  logic             div_q;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [GR_W-1:0]  good_run, good_run_n;
  logic [CNT_W-1:0] period_n;
  logic             period_valid_n;
  logic             locked_n;
  logic             err_n;
  logic [ERR_W-1:0] err_count_n;

  logic             rise;
  logic signed [CNT_W:0] diff;
  logic             in_tol;
  logic             err_event;
  logic             good_event;

  assign rise   = div_in & ~div_q;
  // One extra bit keeps the difference signed without overflow for any cnt.
  assign diff   = $signed({1'b0, cnt}) - EXP_S;
  assign in_tol = (diff <= TOL_S) && (diff >= -TOL_S);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= 1'b0;
      cnt          <= '0;
      good_run     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      err_count    <= '0;
    end else begin
      div_q        <= div_in;
      cnt          <= cnt_n;
      good_run     <= good_run_n;
      period       <= period_n;
      period_valid <= period_valid_n;
      locked       <= locked_n;
      err          <= err_n;
      err_count    <= err_count_n;
    end
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    good_run_n     = good_run;
    period_n       = period;
    period_valid_n = 1'b0;
    locked_n       = locked;
    err_event      = 1'b0;
    good_event     = 1'b0;

    case (state)
      IDLE: begin
        cnt_n      = '0;
        good_run_n = '0;
        locked_n   = 1'b0;
        if (enable) state_n = ARM;
      end
      ARM: begin
        if (!enable) begin
          state_n    = IDLE;
          cnt_n      = '0;
          good_run_n = '0;
          locked_n   = 1'b0;
        end else if (rise) begin
          cnt_n   = CNT_W'(1);
          state_n = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_n    = IDLE;
          cnt_n      = '0;
          good_run_n = '0;
          locked_n   = 1'b0;
        end else if (rise) begin
          period_n       = cnt;
          period_valid_n = 1'b1;
          cnt_n          = CNT_W'(1);
          if (in_tol) good_event = 1'b1;
          else        err_event  = 1'b1;
        end else if (cnt == CNT_MAX) begin
          // Stuck divider: report a full-scale period and re-arm.
          period_n       = CNT_MAX;
          period_valid_n = 1'b1;
          cnt_n          = '0;
          state_n        = ARM;
          err_event      = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (good_event) begin
      if (good_run != GR_MAX) good_run_n = good_run + 1'b1;
      if (good_run_n == GR_MAX) locked_n = 1'b1;
    end
    if (err_event) begin
      good_run_n = '0;
      locked_n   = 1'b0;
    end

    // Clear is applied first so a coincident error event leaves err_count = 1.
    err_n       = clear_err ? 1'b0 : err;
    err_count_n = clear_err ? '0 : err_count;
    if (err_event) begin
      err_n = 1'b1;
      if (err_count_n != ERR_MAX) err_count_n = err_count_n + 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_div_checker.sv
module tb_clk_div_checker;

  logic       clk;
  logic       reset;
  logic       clear_err;

  logic       div1, en1;
  logic [7:0] period1;
  logic       pv1, locked1, err1;
  logic [7:0] errc1;

  logic       div2, en2;
  logic [7:0] period2;
  logic       pv2, locked2, err2;
  logic [7:0] errc2;

  typedef struct packed {
    logic [7:0] per;
    logic       lk;
    logic       er;
    logic [7:0] ec;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int n_total = 0;
  int n_pass  = 0;

  clk_div_checker #(.EXP_PERIOD(4), .TOL(0), .LOCK_CNT(4), .CNT_W(8), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .div_in(div1), .enable(en1), .clear_err(clear_err),
    .period(period1), .period_valid(pv1), .locked(locked1), .err(err1), .err_count(errc1)
  );

  clk_div_checker #(.EXP_PERIOD(4), .TOL(1), .LOCK_CNT(4), .CNT_W(8), .ERR_W(8)) dut_tol (
    .clk(clk), .reset(reset), .div_in(div2), .enable(en2), .clear_err(clear_err),
    .period(period2), .period_valid(pv2), .locked(locked2), .err(err2), .err_count(errc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic expect_pv(input bit sel, input int eper, input bit elk, input bit eer, input int eec);
    exp_t e;
    e.per = 8'(eper);
    e.lk  = elk;
    e.er  = eer;
    e.ec  = 8'(eec);
    if (sel) q2.push_back(e);
    else     q1.push_back(e);
  endtask

  // Rising edge now, high for h cycles, low for p-h cycles. When chk is set,
  // the expected report produced by this rise (closing the previous period)
  // is queued first.
  task automatic rise_then(input bit sel, input int p, input int h, input bit chkv,
                           input int eper, input bit elk, input bit eer, input int eec,
                           input bit clr);
    if (chkv) expect_pv(sel, eper, elk, eer, eec);
    for (int i = 0; i < p; i++) begin
      if (sel) div2 = (i < h);
      else     div1 = (i < h);
      clear_err = clr && (i == 0);
      @(negedge clk);
    end
    clear_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (pv1) begin
      exp_t e;
      n_total++;
      if (q1.size() == 0) begin
        $display("FAIL pv1_unexpected: period=%0d with no report expected", period1);
      end else begin
        e = q1.pop_front();
        if (period1 == e.per && locked1 == e.lk && err1 == e.er && errc1 == e.ec) n_pass++;
        else $display("FAIL pv1: got period=%0d locked=%0b err=%0b err_count=%0d expected period=%0d locked=%0b err=%0b err_count=%0d",
                      period1, locked1, err1, errc1, e.per, e.lk, e.er, e.ec);
      end
    end
  end

  always @(negedge clk) begin
    if (pv2) begin
      exp_t e;
      n_total++;
      if (q2.size() == 0) begin
        $display("FAIL pv2_unexpected: period=%0d with no report expected", period2);
      end else begin
        e = q2.pop_front();
        if (period2 == e.per && locked2 == e.lk && err2 == e.er && errc2 == e.ec) n_pass++;
        else $display("FAIL pv2: got period=%0d locked=%0b err=%0b err_count=%0d expected period=%0d locked=%0b err=%0b err_count=%0d",
                      period2, locked2, err2, errc2, e.per, e.lk, e.er, e.ec);
      end
    end
  end

  initial begin
    reset = 1'b1; clear_err = 1'b0;
    div1 = 1'b0; en1 = 1'b0; div2 = 1'b0; en2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_period", period1, 0);
    chk("rst_pv", pv1, 0);
    chk("rst_locked", locked1, 0);
    chk("rst_err", err1, 0);
    chk("rst_errc", errc1, 0);
    reset = 1'b0;
    @(negedge clk);

    // Lock at divide-by-4
    en1 = 1'b1;
    @(negedge clk);
    rise_then(0, 4, 2, 0, 0, 0, 0, 0, 0);   // arming rise
    rise_then(0, 4, 2, 1, 4, 0, 0, 0, 0);
    rise_then(0, 4, 2, 1, 4, 0, 0, 0, 0);
    rise_then(0, 4, 2, 1, 4, 0, 0, 0, 0);
    rise_then(0, 4, 2, 1, 4, 1, 0, 0, 0);   // 4th good period locks
    chk("lock_after4", locked1, 1);
    rise_then(0, 6, 4, 1, 4, 1, 0, 0, 0);   // stretched high phase
    rise_then(0, 4, 2, 1, 6, 0, 1, 1, 0);   // 6-cycle period: error
    rise_then(0, 4, 2, 1, 4, 0, 1, 1, 0);
    rise_then(0, 4, 2, 1, 4, 0, 1, 1, 0);
    rise_then(0, 4, 2, 1, 4, 0, 1, 1, 0);
    chk("still_unlocked", locked1, 0);

    // Relock then stuck-low divider timeout
    expect_pv(0, 4, 1, 1, 1);
    expect_pv(0, 255, 0, 1, 2);
    rise_then(0, 300, 1, 0, 0, 0, 0, 0, 0);
    chk("timeout_period", period1, 255);
    chk("timeout_errc", errc1, 2);
    rise_then(0, 4, 2, 0, 0, 0, 0, 0, 0);   // re-arm, no report
    rise_then(0, 6, 3, 1, 4, 0, 1, 2, 0);

    // clear_err coincident with an error, then alone
    rise_then(0, 4, 2, 1, 6, 0, 1, 1, 1);
    rise_then(0, 4, 2, 1, 4, 0, 1, 1, 0);
    rise_then(0, 4, 2, 1, 4, 0, 0, 0, 1);
    chk("clear_err", err1, 0);
    chk("clear_errc", errc1, 0);
    rise_then(0, 4, 2, 1, 4, 0, 0, 0, 0);
    rise_then(0, 4, 2, 1, 4, 1, 0, 0, 0);
    rise_then(0, 2, 2, 1, 4, 1, 0, 0, 0);   // leave mid-period

    // Drop enable mid-period
    en1 = 1'b0; div1 = 1'b0;
    @(negedge clk);
    chk("drop_locked", locked1, 0);
    chk("drop_period_hold", period1, 4);
    repeat (3) @(negedge clk);
    en1 = 1'b1;
    @(negedge clk);
    rise_then(0, 4, 2, 0, 0, 0, 0, 0, 0);   // re-arm, no report
    rise_then(0, 4, 2, 1, 4, 0, 0, 0, 0);

    // Asynchronous reset mid-MEASURE
    #2 reset = 1'b1;
    #1;
    chk("async_period", period1, 0);
    chk("async_locked", locked1, 0);
    chk("async_err", err1, 0);
    chk("async_errc", errc1, 0);
    chk("async_pv", pv1, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rise_then(0, 4, 2, 0, 0, 0, 0, 0, 0);
    rise_then(0, 4, 2, 1, 4, 0, 0, 0, 0);
    en1 = 1'b0; div1 = 1'b0;
    @(negedge clk);

    // TOL = 1 instance: 3, 5, 4 accepted, 6 rejected
    en2 = 1'b1;
    @(negedge clk);
    rise_then(1, 3, 1, 0, 0, 0, 0, 0, 0);
    rise_then(1, 5, 2, 1, 3, 0, 0, 0, 0);
    rise_then(1, 4, 2, 1, 5, 0, 0, 0, 0);
    rise_then(1, 3, 1, 1, 4, 0, 0, 0, 0);
    rise_then(1, 6, 3, 1, 3, 1, 0, 0, 0);
    rise_then(1, 4, 2, 1, 6, 0, 1, 1, 0);
    en2 = 1'b0; div2 = 1'b0;
    repeat (3) @(negedge clk);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
